// File: rtl/deserializer_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
// Holds the default word width and the frame counter width function.
package deserializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // The counter must reach N when a parity bit trails the data bits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Frame bit counter: advances on enable and wraps to zero after wrap_value.
// 'last' marks the bit position that completes a frame.
module deser_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [W-1:0] wrap_value,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == wrap_value);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/serial_to_parallel_deserializer.sv
// Serial bit stream to N-bit word deserializer with valid/ready on both sides.
// Define DESERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module serial_to_parallel_deserializer
  import deserializer_pkg::*;
#(
  parameter int N         = DEFAULT_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_parity_err
);

  localparam int CW = cnt_width(N);
`ifdef DESERIALIZER_PARITY_EN
  localparam int LAST_IDX = N;
`else
  localparam int LAST_IDX = N - 1;
`endif

  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          xfer;
  logic          word_done;
  logic          shift_en;
  logic [N-1:0]  sr;
  logic [N-1:0]  sr_next;
  logic [N-1:0]  word_final;

  // Stall only the frame-completing bit while an unconsumed word is held.
  assign in_ready  = !(cnt_last && out_valid && !out_ready);
  assign xfer      = in_valid && in_ready;
  assign word_done = xfer && cnt_last;
  assign shift_en  = xfer && (cnt < CW'(N));

  deser_bit_counter #(
    .W(CW)
  ) u_bit_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (xfer),
    .wrap_value(CW'(LAST_IDX)),
    .count     (cnt),
    .last      (cnt_last)
  );

  always_comb begin
    sr_next = sr;
    if (LSB_FIRST != 0) begin
      sr_next = {in_bit, sr[N-1:1]};
    end else begin
      sr_next = {sr[N-2:0], in_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= sr_next;
    end
  end

`ifdef DESERIALIZER_PARITY_EN
  logic parity_err_q;

  // The parity bit does not shift; the data word is already complete in sr.
  assign word_final = sr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      parity_err_q <= 1'b0;
    end else if (word_done) begin
      parity_err_q <= ^{sr, in_bit};
    end
  end

  assign out_parity_err = parity_err_q;
`else
  assign word_final     = sr_next;
  assign out_parity_err = 1'b0;
`endif

  // A completing word reloads the output even in the consumption cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (word_done) begin
      out_word  <= word_final;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
